// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - MIPS decoder feeding a DEPTH-entry instruction FIFO; optional macro DECODE_QUEUE_ERET_EN
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [23:0]      out_ctrl,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Control word bit positions
  localparam int REGWRITE  = 0;
  localparam int REGDST    = 1;
  localparam int ALUSRC    = 2;
  localparam int BRANCH    = 3;
  localparam int BAL       = 4;
  localparam int JUMP      = 5;
  localparam int JAL       = 6;
  localparam int JR        = 7;
  localparam int MEMTOREG  = 8;
  localparam int LOAD_SIGN = 9;
  localparam int MEM_WR    = 12;
  localparam int MEM_RD    = 13;
  localparam int HILOWRITE = 14;
  localparam int HILOTOREG = 15;
  localparam int CP0_WR    = 16;
  localparam int CP0_RD    = 17;
  localparam int EX_RI     = 18;
  localparam int EX_BP     = 19;
  localparam int EX_SYS    = 20;
  localparam int ERET      = 21;
  localparam int IN_DS     = 22;
  localparam int SRAM_EN   = 23;

  logic [5:0]       op;
  logic [5:0]       fn;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [23:0]      dec;
  logic             ri;
  logic             cti;

  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             ds_pending;
  logic             push;
  logic             pop;

  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [23:0]      mem_ctrl [DEPTH];

  assign op = in_inst[31:26];
  assign rs = in_inst[25:21];
  assign rt = in_inst[20:16];
  assign rd = in_inst[15:11];
  assign fn = in_inst[5:0];

  // Combinational main decoder for the incoming instruction
  always_comb begin
    dec = '0;
    ri  = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00: begin
            // SLL $0,$0,sa is the canonical NOP and writes nothing
            if (rt != 5'd0 || rd != 5'd0) begin
              dec[REGWRITE] = 1'b1;
              dec[REGDST]   = 1'b1;
            end
          end
          6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: begin
            dec[REGWRITE] = 1'b1;
            dec[REGDST]   = 1'b1;
          end
          6'h10, 6'h12: begin
            dec[REGWRITE]  = 1'b1;
            dec[REGDST]    = 1'b1;
            dec[HILOTOREG] = 1'b1;
          end
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: dec[HILOWRITE] = 1'b1;
          6'h08: dec[JR] = 1'b1;
          6'h09: begin
            dec[REGWRITE] = 1'b1;
            dec[REGDST]   = 1'b1;
            dec[JAL]      = 1'b1;
            dec[JR]       = 1'b1;
          end
          6'h0c: dec[EX_SYS] = 1'b1;
          6'h0d: dec[EX_BP]  = 1'b1;
          default: ri = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: dec[BRANCH] = 1'b1;
          5'h10, 5'h11: begin
            dec[BRANCH]   = 1'b1;
            dec[BAL]      = 1'b1;
            dec[REGWRITE] = 1'b1;
          end
          default: ri = 1'b1;
        endcase
      end
      6'h02: dec[JUMP] = 1'b1;
      6'h03: begin
        dec[JUMP]     = 1'b1;
        dec[JAL]      = 1'b1;
        dec[REGWRITE] = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: dec[BRANCH] = 1'b1;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        dec[REGWRITE] = 1'b1;
        dec[ALUSRC]   = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec[REGWRITE]  = 1'b1;
        dec[ALUSRC]    = 1'b1;
        dec[MEMTOREG]  = 1'b1;
        dec[MEM_RD]    = 1'b1;
        dec[SRAM_EN]   = 1'b1;
        // LBU/LHU have op[2] set and zero-extend
        dec[LOAD_SIGN] = ~op[2];
        case (op[1:0])
          2'b00:   dec[11:10] = 2'd1;
          2'b01:   dec[11:10] = 2'd2;
          default: dec[11:10] = 2'd3;
        endcase
      end
      6'h28, 6'h29, 6'h2b: begin
        dec[ALUSRC]  = 1'b1;
        dec[MEM_WR]  = 1'b1;
        dec[SRAM_EN] = 1'b1;
        case (op[1:0])
          2'b00:   dec[11:10] = 2'd1;
          2'b01:   dec[11:10] = 2'd2;
          default: dec[11:10] = 2'd3;
        endcase
      end
      6'h10: begin
        if (rs == 5'h00) begin
          dec[REGWRITE] = 1'b1;
          dec[CP0_RD]   = 1'b1;
        end else if (rs == 5'h04) begin
          dec[CP0_WR] = 1'b1;
        end else begin
`ifdef DECODE_QUEUE_ERET_EN
          if (in_inst == 32'h4200_0018) dec[ERET] = 1'b1;
          else ri = 1'b1;
`else
          ri = 1'b1;
`endif
        end
      end
      default: ri = 1'b1;
    endcase
    // A reserved instruction carries nothing but the exception flag
    if (ri) begin
      dec        = '0;
      dec[EX_RI] = 1'b1;
    end
  end

  assign cti       = dec[BRANCH] | dec[JUMP] | dec[JR];
  assign in_ready  = !rst && !flush && (cnt < FULL);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  assign out_inst = out_valid ? mem_inst[rd_ptr] : '0;
  assign out_pc   = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_ctrl = out_valid ? mem_ctrl[rd_ptr] : '0;

  // Occupancy, pointers and delay-slot tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ds_pending <= 1'b0;
    end else if (flush) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ds_pending <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        ds_pending <= cti;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are left unreset because outputs are masked
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
      mem_ctrl[wr_ptr] <= dec | (ds_pending ? (24'h1 << IN_DS) : 24'h0);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue against a queue-based reference model
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [23:0]      out_ctrl;
  logic [CNT_W-1:0] count;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [23:0] ctrl;
  } ent_t;

  ent_t mq[$];
  bit   m_ds = 1'b0;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_ctrl(out_ctrl), .count(count)
  );

  always #5 clk = ~clk;

  // Reference decode: classify the instruction, then set the named effects
  function automatic logic [23:0] ref_decode(input logic [31:0] w);
    bit rw = 0, rdst = 0, imm = 0, br = 0, bal = 0, jmp = 0, jal = 0, jr = 0;
    bit m2r = 0, lsign = 0, mwr = 0, mrd = 0, hlw = 0, hlr = 0, c0w = 0, c0r = 0;
    bit bp = 0, sys = 0, er = 0, ri = 0;
    logic [1:0] msize = 2'd0;
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    logic [4:0] rs = w[25:21];
    logic [4:0] rt = w[20:16];
    logic [4:0] rd = w[15:11];
    case (op)
      6'd0: begin
        if (fn == 6'd0 && rt == 5'd0 && rd == 5'd0) begin
          // nop: no effect
        end else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}
                     || (fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2a || fn == 6'h2b) begin
          rw = 1; rdst = 1;
        end else if (fn == 6'h10 || fn == 6'h12) begin
          rw = 1; rdst = 1; hlr = 1;
        end else if (fn == 6'h11 || fn == 6'h13 || (fn >= 6'h18 && fn <= 6'h1b)) begin
          hlw = 1;
        end else if (fn == 6'h08) begin
          jr = 1;
        end else if (fn == 6'h09) begin
          jr = 1; jal = 1; rw = 1; rdst = 1;
        end else if (fn == 6'h0c) begin
          sys = 1;
        end else if (fn == 6'h0d) begin
          bp = 1;
        end else begin
          ri = 1;
        end
      end
      6'd1: begin
        if (rt == 5'h00 || rt == 5'h01) br = 1;
        else if (rt == 5'h10 || rt == 5'h11) begin br = 1; bal = 1; rw = 1; end
        else ri = 1;
      end
      6'd2: jmp = 1;
      6'd3: begin jmp = 1; jal = 1; rw = 1; end
      6'd4, 6'd5, 6'd6, 6'd7: br = 1;
      6'h20: begin rw = 1; imm = 1; m2r = 1; mrd = 1; lsign = 1; msize = 2'd1; end
      6'h21: begin rw = 1; imm = 1; m2r = 1; mrd = 1; lsign = 1; msize = 2'd2; end
      6'h23: begin rw = 1; imm = 1; m2r = 1; mrd = 1; lsign = 1; msize = 2'd3; end
      6'h24: begin rw = 1; imm = 1; m2r = 1; mrd = 1; msize = 2'd1; end
      6'h25: begin rw = 1; imm = 1; m2r = 1; mrd = 1; msize = 2'd2; end
      6'h28: begin imm = 1; mwr = 1; msize = 2'd1; end
      6'h29: begin imm = 1; mwr = 1; msize = 2'd2; end
      6'h2b: begin imm = 1; mwr = 1; msize = 2'd3; end
      6'h10: begin
        if (rs == 5'd0) begin rw = 1; c0r = 1; end
        else if (rs == 5'd4) c0w = 1;
`ifdef DECODE_QUEUE_ERET_EN
        else if (w == 32'h4200_0018) er = 1;
`endif
        else ri = 1;
      end
      default: begin
        if (op >= 6'h08 && op <= 6'h0f) begin rw = 1; imm = 1; end
        else ri = 1;
      end
    endcase
    if (ri) return 24'h04_0000;
    return {(mrd | mwr), 1'b0, er, sys, bp, 1'b0, c0r, c0w, hlr, hlw, mrd, mwr, msize,
            lsign, m2r, jr, jal, jmp, bal, br, imm, rdst, rw};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 5)
      0: ;
      1: begin w[31:26] = 6'd0; w[5:0] = 6'($urandom_range(0, 43)); end
      2: w[31:26] = 6'($urandom_range(1, 16));
      3: w[31:26] = 6'($urandom_range(32, 43));
      default: begin
        case ($urandom % 6)
          0: w = 32'h0000_0000;
          1: w = 32'h4200_0018;
          2: w = 32'h0000_000c;
          3: w = 32'h0000_000d;
          4: w = 32'h4080_0000 | (w & 32'h001f_f800);
          default: w = 32'h0800_0000 | (w & 32'h03ff_ffff);
        endcase
      end
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t h;
    bit   v;
    v = (mq.size() != 0);
    if (v) h = mq[0];
    else h = '{32'h0, 32'h0, 24'h0};
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("in_ready", 32'(in_ready), 32'(!rst && !flush && mq.size() < DEPTH));
    chk("out_inst", out_inst, h.inst);
    chk("out_pc", out_pc, h.pc);
    chk("out_ctrl", 32'(out_ctrl), 32'(h.ctrl));
  endtask

  // Advance one clock: model update from the inputs present at the edge
  task automatic tick();
    bit          m_push, m_pop;
    logic [23:0] c;
    m_push = in_valid && !flush && (mq.size() < DEPTH);
    m_pop  = (mq.size() != 0) && out_ready;
    c = ref_decode(in_inst) | (m_ds ? 24'h40_0000 : 24'h0);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_ds = 1'b0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back('{in_inst, in_pc, c});
        m_ds = c[3] | c[5] | c[7];
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // ADDU
    drive(1'b1, 32'h0022_1821, 32'h0000_0100, 1'b0, 1'b0);
    tick();
    chk("addu_ctrl", 32'(out_ctrl), 32'h00_0003);
    chk("addu_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // LW then pop to empty
    drive(1'b1, 32'h8c22_0004, 32'h0000_0104, 1'b0, 1'b0);
    tick();
    chk("lw_ctrl", 32'(out_ctrl), 32'h80_2f05);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("empty_inst", out_inst, 32'h0);
    chk("empty_ctrl", 32'(out_ctrl), 32'h0);

    // BEQ then NOP in its delay slot
    drive(1'b1, 32'h1022_0003, 32'h0000_0200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0000, 32'h0000_0204, 1'b0, 1'b0);
    tick();
    chk("beq_ctrl", 32'(out_ctrl), 32'h00_0008);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("nop_ds_ctrl", 32'(out_ctrl), 32'h40_0000);
    tick();

    // Fill, then pop with in_valid held: no bypass on full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h2401_0000 | 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h2401_0010, 32'h0000_0400, 1'b1, 1'b0);
    tick();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h2401_0020 | 32'(i), 32'h500 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) tick();

    // Flush with ds_pending set, push and pop requested
    drive(1'b1, 32'h0022_1821, 32'h600, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 32'h0800_0000, 32'h608, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0022_1821, 32'h60c, 1'b1, 1'b1);
    tick();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h0022_1821, 32'h700, 1'b0, 1'b0);
    tick();
    chk("post_flush_ctrl", 32'(out_ctrl), 32'h00_0003);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // Exceptions and ERET
    drive(1'b1, 32'h0000_000c, 32'h800, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hfc00_0000, 32'h804, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h4200_0018, 32'h808, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sys_ctrl", 32'(out_ctrl), 32'h10_0000);
    tick();
    chk("ri_ctrl", 32'(out_ctrl), 32'h04_0000);
    tick();
`ifdef DECODE_QUEUE_ERET_EN
    chk("eret_ctrl", 32'(out_ctrl), 32'h20_0000);
`else
    chk("eret_ctrl", 32'(out_ctrl), 32'h04_0000);
`endif
    tick();

    // Randomised traffic with a mid-run asynchronous reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd0);
        mq.delete();
        m_ds = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();
        @(negedge clk);
      end
      drive(($urandom % 4) != 0, rand_inst(), $urandom, ($urandom % 3) != 0, ($urandom % 32) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
